spart_ctrl: RTL and testbench

Bus-side controller that owns the SPART register interface (iocs_n/iorw_n/ioaddr/databus). After reset it programs the baud divisor, then services the SPART continuously. It arbitrates two byte-stream transmit requesters round-robin into the TX queue, drains the RX queue into a one-entry holding register for a single consumer, and applies runtime divisor reloads. It is the only master on the SPART bus.

---
 rtl/spart_ctrl_if.sv | 22 ++
 rtl/spart_ctrl.sv | 121 ++++++++++++
 tb/tb_spart_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_ctrl_if.sv
// Client-side handshakes of spart_ctrl: divisor reload, two TX byte requesters, RX byte consumer.
interface spart_ctrl_if;
  logic [12:0] cfg_div;
  logic        cfg_load;
  logic        cfg_busy;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;

  modport master (
    output cfg_div, cfg_load, req_valid, req_data, rx_ready,
    input  cfg_busy, req_ready, rx_valid, rx_data
  );

  modport slave (
    input  cfg_div, cfg_load, req_valid, req_data, rx_ready,
    output cfg_busy, req_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/spart_ctrl.sv
// Sole bus master for a SPART: programs the divisor after reset, applies reloads,
// round-robins two TX requesters into the TX queue and drains the RX queue.
module spart_ctrl #(
  parameter logic [12:0] DIV_DEFAULT = 13'h01B2
) (
  input  logic        clk,
  input  logic        rst,
  spart_ctrl_if.slave host,
  output logic        iocs_n,
  output logic        iorw_n,
  output logic [1:0]  ioaddr,
  inout  wire  [7:0]  databus,
  input  logic        tx_q_full,
  input  logic        rx_q_empty
);

  localparam logic [2:0] INIT_LO = 3'd0;
  localparam logic [2:0] INIT_HI = 3'd1;
  localparam logic [2:0] GAP     = 3'd2;
  localparam logic [2:0] IDLE    = 3'd3;
  localparam logic [2:0] CFG_LO  = 3'd4;
  localparam logic [2:0] CFG_HI  = 3'd5;
  localparam logic [2:0] WR_TX   = 3'd6;
  localparam logic [2:0] RD_RX   = 3'd7;

  logic [2:0]  state, state_nx;
  logic [12:0] cfg_shadow;
  logic        cfg_pend, cfg_again, cfg_busy_q;
  logic        rr_ptr;
  logic [7:0]  tx_byte;
  logic        rx_valid_q;
  logic [7:0]  rx_data_q;

  logic        rd_go, tx_go, gnt;
  logic [1:0]  grant;
  logic        access, wr;
  logic [1:0]  addr;
  logic [7:0]  wdata;

  always_comb begin
    rd_go    = !rx_q_empty && !rx_valid_q;
    tx_go    = !tx_q_full && (|host.req_valid);
    // both valid: the requester not granted last time wins
    gnt      = (&host.req_valid) ? ~rr_ptr : host.req_valid[1];
    grant    = 2'b00;
    state_nx = state;
    case (state)
      INIT_LO: state_nx = INIT_HI;
      CFG_LO:  state_nx = CFG_HI;
      GAP:     state_nx = IDLE;
      IDLE: begin
        if (cfg_pend)   state_nx = CFG_LO;
        else if (rd_go) state_nx = RD_RX;
        else if (tx_go) begin
          state_nx = WR_TX;
          grant    = gnt ? 2'b10 : 2'b01;
        end
      end
      default: state_nx = GAP;
    endcase
  end

  // Outputs gated by rst so the bus releases the instant reset hits.
  always_comb begin
    access = !rst && (state != GAP) && (state != IDLE);
    wr     = access && (state != RD_RX);
    addr   = 2'b00;
    wdata  = tx_byte;
    case (state)
      INIT_LO: begin addr = 2'b10; wdata = DIV_DEFAULT[7:0]; end
      INIT_HI: begin addr = 2'b11; wdata = {3'b000, DIV_DEFAULT[12:8]}; end
      CFG_LO:  begin addr = 2'b10; wdata = cfg_shadow[7:0]; end
      CFG_HI:  begin addr = 2'b11; wdata = {3'b000, cfg_shadow[12:8]}; end
      default: ;
    endcase
  end

  assign iocs_n  = !access;
  assign iorw_n  = !wr;
  assign ioaddr  = access ? addr : 2'b00;
  assign databus = wr ? wdata : 8'hzz;

  assign host.req_ready = grant;
  assign host.rx_valid  = rx_valid_q;
  assign host.rx_data   = rx_data_q;
  assign host.cfg_busy  = cfg_busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT_LO;
      cfg_shadow <= '0;
      cfg_pend   <= 1'b0;
      cfg_again  <= 1'b0;
      cfg_busy_q <= 1'b1;
      rr_ptr     <= 1'b1;
      tx_byte    <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state <= state_nx;
      if (host.cfg_load) cfg_shadow <= host.cfg_div;
      // a load landing mid-reload may have split the divisor; keep it pending for another pass
      cfg_again <= (state == CFG_LO) && host.cfg_load;
      if (state == CFG_HI)    cfg_pend <= host.cfg_load | cfg_again;
      else if (host.cfg_load) cfg_pend <= 1'b1;
      if (host.cfg_load)                   cfg_busy_q <= 1'b1;
      else if (state == GAP && !cfg_pend)  cfg_busy_q <= 1'b0;
      if (|grant) begin
        tx_byte <= gnt ? host.req_data[15:8] : host.req_data[7:0];
        rr_ptr  <= gnt;
      end
      if (state == RD_RX) begin
        rx_data_q  <= databus;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && host.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spart_ctrl.sv
// Scoreboard bench for spart_ctrl: expected bus accesses and grants are queued, then matched as they appear.
module tb_spart_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spart_ctrl_if hif();
  logic       iocs_n, iorw_n;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       tx_q_full, rx_q_empty;
  logic [7:0] spart_rd;

  // SPART model: returns spart_rd on reads, holds the bus at 00 while deselected
  assign databus = iocs_n ? 8'h00 : (iorw_n ? spart_rd : 8'hzz);

  spart_ctrl dut (
    .clk(clk), .rst(rst), .host(hif),
    .iocs_n(iocs_n), .iorw_n(iorw_n), .ioaddr(ioaddr), .databus(databus),
    .tx_q_full(tx_q_full), .rx_q_empty(rx_q_empty)
  );

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q[$];
  logic [1:0]  rdy_q[$];

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if ({iocs_n, iorw_n, ioaddr} !== 4'b1100) begin bad++; $display("FAIL reset_bus: got %b want 1100", {iocs_n, iorw_n, ioaddr}); end
    total++; if (databus !== 8'h00) begin bad++; $display("FAIL reset_data_released: got %h want 00", databus); end
    total++; if ({hif.req_ready, hif.rx_valid, hif.rx_data, hif.cfg_busy} !== 12'b00_0_00000000_1)
      begin bad++; $display("FAIL reset_outs: got %b want 000000000001", {hif.req_ready, hif.rx_valid, hif.rx_data, hif.cfg_busy}); end
    @(posedge clk); #1 rst = 1'b0;
    exp_q.push_back({1'b0, 2'd2, 8'hB2});
    exp_q.push_back({1'b0, 2'd3, 8'h01});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c < 2) begin
        total++;
        if (iocs_n !== 1'b0 || {iorw_n, ioaddr, databus} !== exp_q[0])
          begin bad++; $display("FAIL init_write%0d: got cs=%b %h want %h", c, iocs_n, {iorw_n, ioaddr, databus}, exp_q[0]); end
        void'(exp_q.pop_front());
      end else if (c == 2) begin
        total++; if ({iocs_n, hif.cfg_busy} !== 2'b11) begin bad++; $display("FAIL init_gap: got cs/busy=%b want 11", {iocs_n, hif.cfg_busy}); end
      end else begin
        total++; if ({iocs_n, hif.cfg_busy, databus} !== {2'b10, 8'h00})
          begin bad++; $display("FAIL init_idle: got cs/busy=%b data=%h want 10 00", {iocs_n, hif.cfg_busy}, databus); end
      end
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    @(posedge clk); #1 hif.req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      rdy_q.push_back(2'b01); exp_q.push_back({1'b0, 2'd0, 8'h41});
      rdy_q.push_back(2'b10); exp_q.push_back({1'b0, 2'd0, 8'h42});
    end
    while ((exp_q.size() != 0 || rdy_q.size() != 0) && n < 30) begin
      @(negedge clk); n++;
      if (hif.req_ready != 2'b00) begin
        total++;
        if (rdy_q.size() == 0) begin bad++; $display("FAIL rr_ready: got %b want none", hif.req_ready); end
        else begin
          if (hif.req_ready !== rdy_q[0]) begin bad++; $display("FAIL rr_ready: got %b want %b", hif.req_ready, rdy_q[0]); end
          void'(rdy_q.pop_front());
        end
      end
      if (!iocs_n) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rr_access: got %h want none", {iorw_n, ioaddr, databus}); end
        else begin
          if ({iorw_n, ioaddr, databus} !== exp_q[0]) begin bad++; $display("FAIL rr_access: got %h want %h", {iorw_n, ioaddr, databus}, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
    end
    total++; if (exp_q.size() + rdy_q.size() != 0) begin bad++; $display("FAIL rr_timeout: got %0d left want 0", exp_q.size() + rdy_q.size()); end
    exp_q.delete(); rdy_q.delete();
    @(posedge clk); #1 hif.req_valid = 2'b00;
  endtask

  task automatic test_tx_full();
    logic seen = 1'b0;
    int n = 0;
    @(posedge clk); #1 tx_q_full = 1'b1; hif.req_valid = 2'b01;
    repeat (6) begin
      @(negedge clk);
      if (!iocs_n || hif.req_ready != 2'b00) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL txfull_block: got activity=1 want 0"); end
    @(posedge clk); #1 tx_q_full = 1'b0;
    rdy_q.push_back(2'b01); exp_q.push_back({1'b0, 2'd0, 8'h41});
    while ((exp_q.size() != 0 || rdy_q.size() != 0) && n < 3) begin
      @(negedge clk); n++;
      if (hif.req_ready != 2'b00 && rdy_q.size() != 0) begin
        total++; if (hif.req_ready !== rdy_q[0]) begin bad++; $display("FAIL txfull_ready: got %b want %b", hif.req_ready, rdy_q[0]); end
        void'(rdy_q.pop_front());
      end
      if (!iocs_n && exp_q.size() != 0) begin
        total++; if ({iorw_n, ioaddr, databus} !== exp_q[0]) begin bad++; $display("FAIL txfull_write: got %h want %h", {iorw_n, ioaddr, databus}, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    total++; if (exp_q.size() + rdy_q.size() != 0) begin bad++; $display("FAIL txfull_timeout: got %0d left want 0", exp_q.size() + rdy_q.size()); end
    exp_q.delete(); rdy_q.delete();
    @(posedge clk); #1 hif.req_valid = 2'b00;
  endtask

  task automatic test_rx();
    int n = 0;
    @(posedge clk); #1 spart_rd = 8'h5A; rx_q_empty = 1'b0; hif.rx_ready = 1'b0;
    exp_q.push_back({1'b1, 2'd0, 8'h5A});
    repeat (8) begin
      @(negedge clk);
      if (!iocs_n) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rx_extra_read: got %h want none", {iorw_n, ioaddr, databus}); end
        else begin
          if ({iorw_n, ioaddr, databus} !== exp_q[0]) begin bad++; $display("FAIL rx_read: got %h want %h", {iorw_n, ioaddr, databus}, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rx_missing_read: got %0d left want 0", exp_q.size()); end
    total++; if ({hif.rx_valid, hif.rx_data} !== {1'b1, 8'h5A}) begin bad++; $display("FAIL rx_hold: got %b/%h want 1/5a", hif.rx_valid, hif.rx_data); end
    exp_q.delete();
    @(posedge clk); #1 hif.rx_ready = 1'b1;
    @(posedge clk); #1 hif.rx_ready = 1'b0; spart_rd = 8'h6B;
    exp_q.push_back({1'b1, 2'd0, 8'h6B});
    @(negedge clk);
    total++; if (hif.rx_valid !== 1'b0) begin bad++; $display("FAIL rx_clear: got %b want 0", hif.rx_valid); end
    while (exp_q.size() != 0 && n < 4) begin
      @(negedge clk); n++;
      if (!iocs_n) begin
        total++; if ({iorw_n, ioaddr, databus} !== exp_q[0]) begin bad++; $display("FAIL rx_next_read: got %h want %h", {iorw_n, ioaddr, databus}, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rx_next_timeout: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
    @(posedge clk); #1 rx_q_empty = 1'b1;
    @(negedge clk);
    total++; if ({hif.rx_valid, hif.rx_data} !== {1'b1, 8'h6B}) begin bad++; $display("FAIL rx_second: got %b/%h want 1/6b", hif.rx_valid, hif.rx_data); end
    hif.rx_ready = 1'b1;
    @(posedge clk); #1 hif.rx_ready = 1'b0;
  endtask

  task automatic test_cfg_reload();
    logic found = 1'b0;
    int n = 0;
    @(posedge clk); #1 hif.req_valid = 2'b01;
    while (!found && n < 8) begin
      @(negedge clk); n++;
      if (!iocs_n && !iorw_n && ioaddr == 2'd0) found = 1'b1;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL cfg_first_tx: got none want write"); end
    @(posedge clk); #1 hif.cfg_div = 13'h0545; hif.cfg_load = 1'b1; rx_q_empty = 1'b0; spart_rd = 8'h77;
    @(posedge clk); #1 hif.cfg_load = 1'b0;
    exp_q.push_back({1'b0, 2'd2, 8'h45});
    exp_q.push_back({1'b0, 2'd3, 8'h05});
    exp_q.push_back({1'b1, 2'd0, 8'h77});
    exp_q.push_back({1'b0, 2'd0, 8'h41});
    rdy_q.push_back(2'b01);
    @(negedge clk);
    total++; if ({hif.cfg_busy, hif.req_ready} !== 3'b100) begin bad++; $display("FAIL cfg_pending: got busy/ready=%b want 100", {hif.cfg_busy, hif.req_ready}); end
    n = 0;
    while ((exp_q.size() != 0 || rdy_q.size() != 0) && n < 20) begin
      @(negedge clk); n++;
      if (hif.req_ready != 2'b00) begin
        total++;
        if (rdy_q.size() == 0 || exp_q.size() != 1) begin bad++; $display("FAIL cfg_ready: got %b with %0d accesses left want 1", hif.req_ready, exp_q.size()); end
        else begin
          if (hif.req_ready !== rdy_q[0]) begin bad++; $display("FAIL cfg_ready: got %b want %b", hif.req_ready, rdy_q[0]); end
          void'(rdy_q.pop_front());
        end
      end
      if (!iocs_n && exp_q.size() != 0) begin
        total++; if ({iorw_n, ioaddr, databus} !== exp_q[0]) begin bad++; $display("FAIL cfg_access: got %h want %h", {iorw_n, ioaddr, databus}, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    total++; if (exp_q.size() + rdy_q.size() != 0) begin bad++; $display("FAIL cfg_timeout: got %0d left want 0", exp_q.size() + rdy_q.size()); end
    total++; if (hif.cfg_busy !== 1'b0) begin bad++; $display("FAIL cfg_done: got busy=%b want 0", hif.cfg_busy); end
    exp_q.delete(); rdy_q.delete();
    @(posedge clk); #1 hif.req_valid = 2'b00; rx_q_empty = 1'b1; hif.rx_ready = 1'b1;
    @(posedge clk); #1 hif.rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    logic found = 1'b0;
    int n = 0;
    @(posedge clk); #1 hif.req_valid = 2'b01;
    while (!found && n < 8) begin
      @(negedge clk); n++;
      if (!iocs_n && !iorw_n && ioaddr == 2'd0) found = 1'b1;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL mid_tx_seen: got none want write"); end
    #1 rst = 1'b1; hif.req_valid = 2'b00;
    #1;
    total++; if ({iocs_n, iorw_n, databus, hif.cfg_busy} !== {2'b11, 8'h00, 1'b1})
      begin bad++; $display("FAIL mid_reset_release: got cs/rw=%b data=%h busy=%b want 11 00 1", {iocs_n, iorw_n}, databus, hif.cfg_busy); end
    @(posedge clk); #1 rst = 1'b0;
    exp_q.push_back({1'b0, 2'd2, 8'hB2});
    exp_q.push_back({1'b0, 2'd3, 8'h01});
    n = 0;
    while (exp_q.size() != 0 && n < 4) begin
      @(negedge clk); n++;
      if (!iocs_n) begin
        total++; if ({iorw_n, ioaddr, databus} !== exp_q[0]) begin bad++; $display("FAIL mid_reinit: got %h want %h", {iorw_n, ioaddr, databus}, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mid_reinit_timeout: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hif.cfg_div   = '0;
    hif.cfg_load  = 1'b0;
    hif.req_valid = 2'b00;
    hif.req_data  = {8'h42, 8'h41};
    hif.rx_ready  = 1'b0;
    tx_q_full     = 1'b0;
    rx_q_empty    = 1'b1;
    spart_rd      = 8'h00;
    test_reset();
    test_round_robin();
    test_tx_full();
    test_rx();
    test_cfg_reload();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
